// File: rtl/id_token_stat.sv
// ============================================================================
// Module  : id_token_stat
// Purpose : Splits the identifier-FSM character stream into alphanumeric
//           tokens; reports per-token length/classification and keeps
//           saturating identifier statistics.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_token_stat #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char,
  input  logic             match,
  input  logic             clr,
  output logic             tok_valid,
  output logic             tok_ok,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] id_count,
  output logic [LEN_W-1:0] max_len
);

  localparam logic [LEN_W-1:0] c_len_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_TOK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cur_len;
  logic [LEN_W-1:0] w_cur_len_nxt;
  logic             w_is_alnum;
  logic             w_done;

  always_comb begin
    w_is_alnum = ((char >= 8'h30) && (char <= 8'h39)) ||
                 ((char >= 8'h41) && (char <= 8'h5A)) ||
                 ((char >= 8'h61) && (char <= 8'h7A));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cur_len <= '0;
    end else if (clr) begin
      r_state   <= IDLE;
      r_cur_len <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_len <= w_cur_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_len_nxt = r_cur_len;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_is_alnum) begin
          w_state_nxt   = IN_TOK;
          w_cur_len_nxt = LEN_W'(1);
        end
      end
      IN_TOK: begin
        if (w_is_alnum) begin
          // Length sticks at all-ones; extra characters are not counted.
          if (r_cur_len != c_len_max) begin
            w_cur_len_nxt = r_cur_len + LEN_W'(1);
          end
        end else begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // match still reflects the FSM after the token's last character on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_valid <= 1'b0;
      tok_ok    <= 1'b0;
      tok_len   <= '0;
      id_count  <= '0;
      max_len   <= '0;
    end else if (clr) begin
      tok_valid <= 1'b0;
      tok_ok    <= 1'b0;
      tok_len   <= '0;
      id_count  <= '0;
      max_len   <= '0;
    end else begin
      tok_valid <= w_done;
      if (w_done) begin
        tok_ok  <= match;
        tok_len <= r_cur_len;
        if (match) begin
          if (id_count != c_cnt_max) begin
            id_count <= id_count + CNT_W'(1);
          end
          if (r_cur_len > max_len) begin
            max_len <= r_cur_len;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_token_stat.sv
// ============================================================================
// Module  : tb_id_token_stat
// Purpose : Directed self-checking bench; a default-size and a small
//           (LEN_W=3, CNT_W=2) instance share one stimulus stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_token_stat;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char = 8'h20;
  logic       clr = 1'b0;
  logic       match;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        v0, ok0, v1, ok1;
  logic [7:0]  len0, max0;
  logic [15:0] cnt0;
  logic [2:0]  len1, max1;
  logic [1:0]  cnt1;

  id_token_stat #(.LEN_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .char(char), .match(match), .clr(clr),
    .tok_valid(v0), .tok_ok(ok0), .tok_len(len0), .id_count(cnt0), .max_len(max0)
  );

  id_token_stat #(.LEN_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .char(char), .match(match), .clr(clr),
    .tok_valid(v1), .tok_ok(ok1), .tok_len(len1), .id_count(cnt1), .max_len(max1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference identifier recogniser: letter first, then letters/digits.
  int fsm;  // 0 start, 1 identifier so far, 2 rejected
  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction
  function automatic bit is_digit(input logic [7:0] c);
    return (c >= "0" && c <= "9");
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= 0;
    else if (is_alpha(char)) fsm <= (fsm == 0) ? 1 : fsm;
    else if (is_digit(char)) fsm <= (fsm == 0) ? 2 : fsm;
    else fsm <= 0;
  end
  assign match = force_en ? force_val : (fsm == 1);

  // Behavioural model: unbounded counts, saturation applied when reporting.
  int lmax [2] = '{255, 7};
  int cmax [2] = '{65535, 3};
  bit m_active [2];
  int m_len [2];
  int m_ids [2];
  int m_best [2];
  bit e_valid [2];
  bit e_ok [2];
  int e_len [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || clr) begin
        m_active[i] = 0; m_len[i] = 0; m_ids[i] = 0; m_best[i] = 0;
        e_valid[i] = 0; e_ok[i] = 0; e_len[i] = 0;
      end else begin
        e_valid[i] = 0;
        if (is_alpha(char) || is_digit(char)) begin
          m_len[i] = m_active[i] ? m_len[i] + 1 : 1;
          m_active[i] = 1;
        end else if (m_active[i]) begin
          m_active[i] = 0;
          e_valid[i] = 1;
          e_ok[i] = match;
          e_len[i] = (m_len[i] > lmax[i]) ? lmax[i] : m_len[i];
          if (match) begin
            m_ids[i]++;
            if (e_len[i] > m_best[i]) m_best[i] = e_len[i];
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int ex_cnt;
    chk("u_dut tok_valid", int'(v0), int'(e_valid[0]));
    if (e_valid[0]) chk("u_dut tok_ok", int'(ok0), int'(e_ok[0]));
    chk("u_dut tok_len", int'(len0), e_len[0]);
    ex_cnt = (m_ids[0] > cmax[0]) ? cmax[0] : m_ids[0];
    chk("u_dut id_count", int'(cnt0), ex_cnt);
    chk("u_dut max_len", int'(max0), m_best[0]);
    chk("u_sat tok_valid", int'(v1), int'(e_valid[1]));
    if (e_valid[1]) chk("u_sat tok_ok", int'(ok1), int'(e_ok[1]));
    chk("u_sat tok_len", int'(len1), e_len[1]);
    ex_cnt = (m_ids[1] > cmax[1]) ? cmax[1] : m_ids[1];
    chk("u_sat id_count", int'(cnt1), ex_cnt);
    chk("u_sat max_len", int'(max1), m_best[1]);
  end

  // Pulse log for the hand-computed expectations.
  int q_len [$];
  int q_ok [$];
  int q_t [$];
  int sat_last_len = -1;
  always @(negedge clk) begin
    if (v0) begin
      q_len.push_back(int'(len0));
      q_ok.push_back(int'(ok0));
      q_t.push_back(cyc);
    end
    if (v1) sat_last_len = int'(len1);
  end

  task automatic send(input logic [7:0] c, input logic cl = 1'b0);
    @(posedge clk);
    #1;
    char = c;
    clr  = cl;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'h20);
  endtask

  task automatic clear_log();
    q_len.delete(); q_ok.delete(); q_t.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then asynchronous reset in the middle of a token.
    #12;
    chk("reset tok_valid", int'(v0), 0);
    chk("reset id_count", int'(cnt0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("x9 ab");
    @(negedge clk);
    chk("pre-reset id_count", int'(cnt0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset id_count", int'(cnt0), 0);
    chk("async reset tok_len", int'(len0), 0);
    chk("async reset max_len", int'(max0), 0);
    @(negedge clk);
    char = 8'h20;
    rst_n = 1'b1;
    idle(2);
    clear_log();
    send_str("x9 ");
    idle(2);
    chk("x9 pulses", q_len.size(), 1);
    if (q_len.size() == 1) begin
      chk("x9 tok_len", q_len[0], 2);
      chk("x9 tok_ok", q_ok[0], 1);
    end
    chk("x9 id_count", int'(cnt0), 1);

    // Identifier with a real FSM.
    send(8'h20, 1'b1);
    idle(1);
    clear_log();
    send_str("ab12 ");
    idle(2);
    chk("ab12 pulses", q_len.size(), 1);
    if (q_len.size() == 1) chk("ab12 tok_len", q_len[0], 4);
    chk("ab12 id_count", int'(cnt0), 1);
    chk("ab12 max_len", int'(max0), 4);
    chk("model ab12 len", e_len[0], 4);

    // Tokens classified as non-identifiers by the FSM.
    clear_log();
    force_en = 1'b1; force_val = 1'b0;
    send_str("abc 12 ");
    idle(2);
    force_en = 1'b0;
    chk("nonid pulses", q_len.size(), 2);
    if (q_len.size() == 2) begin
      chk("nonid len0", q_len[0], 3);
      chk("nonid len1", q_len[1], 2);
      chk("nonid ok0", q_ok[0], 0);
    end
    chk("nonid id_count", int'(cnt0), 1);
    chk("nonid max_len", int'(max0), 4);

    // Delimiter runs.
    clear_log();
    send_str("  ,;a1  ");
    idle(2);
    chk("delim pulses", q_len.size(), 1);
    if (q_len.size() == 1) chk("delim tok_len", q_len[0], 2);

    // Back-to-back tokens: pulses three cycles apart.
    clear_log();
    send_str("a1 b2 ");
    idle(2);
    chk("b2b pulses", q_t.size(), 2);
    if (q_t.size() == 2) chk("b2b spacing", q_t[1] - q_t[0], 3);

    // Classification belongs to the FSM, not to character order.
    clear_log();
    force_en = 1'b1; force_val = 1'b1;
    send_str("9ab1 ");
    idle(2);
    force_en = 1'b0;
    if (q_ok.size() == 1) chk("9ab1 tok_ok", q_ok[0], 1);
    else chk("9ab1 pulses", q_ok.size(), 1);

    // Saturation on the small instance.
    send(8'h20, 1'b1);
    idle(1);
    clear_log();
    send_str("a1234567890 ");
    idle(2);
    chk("sat tok_len", sat_last_len, 7);
    chk("sat max_len", int'(max1), 7);
    chk("wide tok_len", int'(len0), 11);
    chk("model sat len", e_len[1], 7);
    send_str("b1 c2 d3 e4 ");
    idle(2);
    chk("sat id_count", int'(cnt1), 3);
    chk("wide id_count", int'(cnt0), 5);
    chk("model wide ids", m_ids[0], 5);

    // Clear coincident with the delimiter.
    clear_log();
    send_str("q7");
    send(8'h20, 1'b1);
    idle(2);
    chk("clr pulses", q_len.size(), 0);
    chk("clr id_count", int'(cnt0), 0);
    chk("clr max_len", int'(max0), 0);
    send_str("r8 ");
    idle(2);
    chk("after clr id_count", int'(cnt0), 1);
    chk("after clr pulses", q_len.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
